// File: rtl/micro_hash_nonce_ctrl_if.sv
// Bus between the nonce-search controller, its host/config side and the micro hash core.
// master = controller view, slave = host + core view.
interface micro_hash_nonce_ctrl_if #(
    parameter int BYTE_W = 8
);
    logic                  start;
    logic [12*BYTE_W-1:0]  payload;
    logic [4*BYTE_W-1:0]   nonce_start;
    logic [4*BYTE_W-1:0]   nonce_end;
    logic [3*BYTE_W-1:0]   target;
    logic [3*BYTE_W-1:0]   hash_h;
    logic                  hash_valid;
    logic [16*BYTE_W-1:0]  block;
    logic                  next;
    logic                  finished;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic [4*BYTE_W-1:0]   nonce_out;
    logic [3*BYTE_W-1:0]   h_out;
    logic [4*BYTE_W-1:0]   tries;
    logic                  timeout_err;

    modport master (
        input  start, payload, nonce_start, nonce_end, target, hash_h, hash_valid,
        output block, next, finished, busy, done, found, nonce_out, h_out, tries, timeout_err
    );

    modport slave (
        output start, payload, nonce_start, nonce_end, target, hash_h, hash_valid,
        input  block, next, finished, busy, done, found, nonce_out, h_out, tries, timeout_err
    );
endinterface

// File: rtl/micro_hash_nonce_ctrl.sv
// Nonce-sweep controller for the micro hash core: launches one digest per nonce until one is below target.
// Optional WAIT watchdog enabled by defining MICRO_HASH_CTRL_WATCHDOG_EN.
module micro_hash_nonce_ctrl #(
    parameter int BYTE_W = 8
`ifdef MICRO_HASH_CTRL_WATCHDOG_EN
    , parameter int WDOG_CYCLES = 128
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    micro_hash_nonce_ctrl_if.master bus
);
    localparam int NW = 4 * BYTE_W;
    localparam int HW = 3 * BYTE_W;
    localparam int PW = 12 * BYTE_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_payload;
    logic [NW-1:0]   r_nonce;
    logic [NW-1:0]   r_nonce_end;
    logic [NW-1:0]   r_nonce_out;
    logic [NW-1:0]   r_tries;
    logic [HW-1:0]   r_target;
    logic [HW-1:0]   r_h_out;
    logic            r_next;
    logic            r_finished;
    logic            r_busy;
    logic            r_done;
    logic            r_found;

`ifdef MICRO_HASH_CTRL_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_payload   <= '0;
            r_nonce     <= '0;
            r_nonce_end <= '0;
            r_nonce_out <= '0;
            r_tries     <= '0;
            r_target    <= '0;
            r_h_out     <= '0;
            r_next      <= 1'b0;
            r_finished  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
`ifdef MICRO_HASH_CTRL_WATCHDOG_EN
            r_wdog      <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MICRO_HASH_CTRL_WATCHDOG_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_payload   <= bus.payload;
                        r_target    <= bus.target;
                        r_nonce     <= bus.nonce_start;
                        r_nonce_end <= bus.nonce_end;
                        r_tries     <= '0;
                        r_found     <= 1'b0;
                        r_next      <= 1'b1;
                        r_finished  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_next  <= 1'b0;
`ifdef MICRO_HASH_CTRL_WATCHDOG_EN
                    r_wdog  <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.hash_valid) begin
                        r_h_out <= bus.hash_h;
                        r_tries <= r_tries + NW'(1);
                        r_state <= S_CHECK;
                    end
`ifdef MICRO_HASH_CTRL_WATCHDOG_EN
                    // Core presumed hung: relaunch the same nonce without counting a try.
                    else if (r_wdog == WDOG_W'(WDOG_CYCLES - 1)) begin
                        r_timeout <= 1'b1;
                        r_next    <= 1'b1;
                        r_state   <= S_LAUNCH;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
`endif
                end
                S_CHECK: begin
                    if ((r_h_out < r_target) || (r_nonce == r_nonce_end)) begin
                        r_found     <= (r_h_out < r_target);
                        r_nonce_out <= r_nonce;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_finished  <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_nonce <= r_nonce + NW'(1);
                        r_next  <= 1'b1;
                        r_state <= S_LAUNCH;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Nonce occupies the top four bytes, LSB byte lowest, directly above the payload.
    assign bus.block     = {r_nonce, r_payload};
    assign bus.next      = r_next;
    assign bus.finished  = r_finished;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.found     = r_found;
    assign bus.nonce_out = r_nonce_out;
    assign bus.h_out     = r_h_out;
    assign bus.tries     = r_tries;
`ifdef MICRO_HASH_CTRL_WATCHDOG_EN
    assign bus.timeout_err = r_timeout;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: doc/micro_hash_nonce_ctrl.md
Name: micro_hash_nonce_ctrl

Overview:
- Upstream driver and downstream consumer of the micro hash core.
- Builds the 16-byte message block from a 12-byte payload and a 32-bit nonce, and sequences the core's next/finished controls.
- Captures each 24-bit digest and compares it against a target. The nonce is swept until a digest below the target is found or the nonce range is exhausted.
- Sits between the host/config registers and the hash core; one core instance per controller.

Parameters:
byte, 8, bits per message/digest byte (block = 16*byte, digest = 3*byte)
WDOG_CYCLES, 128, watchdog limit in cycles (used only with MICRO_HASH_CTRL_WATCHDOG_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a search; ignored while busy=1
payload  input  12*byte  message bytes 0..11; byte i in [(i+1)*byte-1 : i*byte]
nonce_start  input  4*byte  first nonce tried
nonce_end  input  4*byte  last nonce tried (inclusive)
target  input  3*byte  success threshold, unsigned
hash_h  input  3*byte  digest from core (core h)
hash_valid  input  1  core valid_out pulse
block  output  16*byte  to core block: payload in [12*byte-1:0], nonce in [16*byte-1:12*byte], nonce LSB byte lowest
next  output  1  to core next: one-cycle clear/launch pulse
finished  output  1  to core finished: parks core in clear
busy  output  1  search in progress
done  output  1  one-cycle pulse at end of search
found  output  1  last search succeeded; held until next start
nonce_out  output  4*byte  winning nonce, or last nonce tried; held
h_out  output  3*byte  digest of nonce_out; held
tries  output  4*byte  digests evaluated in last/current search
timeout_err  output  1  one-cycle watchdog pulse (tied 0 without feature)

Behaviour:
- Reset (async, reset=0):
  - State is IDLE.
  - All outputs are 0 except finished=1.
  - All latched config registers are cleared.
  - Reset mid-search aborts the search immediately; no done pulse is produced.
- FSM states: IDLE, LAUNCH, WAIT, CHECK, DONE. All outputs are registered.
- IDLE:
  - finished=1, next=0, busy=0.
  - On start=1: latch payload, target, nonce_start and nonce_end; nonce<=nonce_start; tries<=0; found<=0; go to LAUNCH.
- LAUNCH (1 cycle):
  - next=1, finished=0, busy=1.
  - block = {nonce, payload_latched}; block stays stable from here until CHECK exits.
  - Go to WAIT.
- WAIT:
  - next=0, finished=0; the core computes.
  - On hash_valid=1: capture hash_h into h_out; tries<=tries+1; go to CHECK.
  - hash_valid in any other state is ignored.
- CHECK (1 cycle):
  - If h_out < target (unsigned): found<=1, nonce_out<=nonce, go to DONE.
  - Else if nonce == nonce_end: found<=0, nonce_out<=nonce, go to DONE.
  - Else: nonce<=nonce+1 (mod 2^32), go to LAUNCH.
- DONE (1 cycle):
  - done=1, busy=0, finished=1.
  - found, nonce_out, h_out and tries hold until the next accepted start.
  - Go to IDLE.
- Per-attempt overhead is 2 cycles (LAUNCH + CHECK) beyond the core's internal latency.
- Boundary cases:
  - target=0: no digest can succeed; the full range is swept and the search ends with found=0.
  - nonce_start == nonce_end: exactly one attempt.
  - nonce_end < nonce_start: the sweep wraps through 0xFFFFFFFF to 0 and stops at nonce_end.
  - tries wraps modulo 2^32.
  - start during busy: ignored, with no effect on latched config.
  - start in the same cycle as DONE: ignored; it is accepted only in IDLE.
  - hash_valid in the same cycle as LAUNCH: ignored, since the core is being cleared.

Optional Feature:
- Macro: MICRO_HASH_CTRL_WATCHDOG_EN.
- Defined:
  - A WAIT cycle counter starts at 0 on WAIT entry.
  - If it reaches WDOG_CYCLES without hash_valid: timeout_err pulses for 1 cycle and the FSM returns to LAUNCH with the same nonce. tries is not incremented.
  - The counter clears on every LAUNCH.
- Not defined:
  - WAIT blocks indefinitely.
  - timeout_err is constant 0 and no counter logic is synthesized.

Test Plan:
- Bench uses a stub core: hash_valid pulses 5 cycles after next falls, with hash_h = ~nonce[23:0].
- Early hit: nonce_start=0xFFFFF0, nonce_end=0xFFFFFFFF, target=0x000005 -> done with found=1, nonce_out=0xFFFFFB, h_out=0x000004, tries=12.
- Miss: nonce_start=0x10, nonce_end=0x13, target=0x000000 -> found=0, nonce_out=0x13, tries=4, exactly 4 next pulses.
- Single attempt and block layout: payload=0x0B0A..00, nonce_start=nonce_end=0xA1B2C3D4 -> block=0xA1B2C3D4_0B0A0908..00 during WAIT, tries=1.
- Start while busy, and async reset mid-WAIT:
  - Second start with different payload is ignored.
  - reset=0 mid-WAIT -> IDLE immediately, finished=1, busy=0, no done pulse.
- Watchdog (macro on, WDOG_CYCLES=8): stub withholds hash_valid for the first attempt -> timeout_err pulse, relaunch with the same nonce, then normal completion with tries=1.
